skynet_mac_accum: RTL and testbench
===================================

Name: skynet_mac_accum

Overview:
- Downstream consumer of the signed 11x9 -> 20-bit DSP48 multiplier stage in the SkyNet conv datapath.
- Accumulates a group of signed products plus a per-group bias.
- Requantizes the final sum by a runtime right-shift with round-half-up.
- Saturates to OUT_W-bit signed activations and presents them on a valid/ready output with one register stage.

Parameters:
- PROD_W, 20, width of signed product input (matches multiplier output).
- BIAS_W, 20, width of signed bias.
- ACC_W, 32, width of signed accumulator; arithmetic is modulo 2^ACC_W.
- OUT_W, 11, width of signed saturated output (feeds next layer's 11-bit multiplier port).
- CNT_W, 16, width of the completed-group counter.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- prod_valid  in  1  product beat valid.
- prod_ready  out  1  block can accept a beat.
- prod_data  in  PROD_W  signed product.
- prod_last  in  1  final beat of the current group.
- cfg_bias  in  BIAS_W  signed bias; sampled on the first beat of a group.
- cfg_shift  in  5  right-shift amount 0..31; sampled on the first beat of a group.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  signed requantized result.
- grp_cnt  out  CNT_W  number of completed groups; wraps modulo 2^CNT_W.
- sat_sticky  out  1  set when any result saturated; cleared only by reset.

Behaviour:
- Reset (async assert, sync deassert by the surrounding design):
  - out_valid=0, out_data=0, grp_cnt=0, sat_sticky=0.
  - Accumulator = 0; first-beat flag = 1; stored shift = 0.
- Handshake:
  - Beat accepted when prod_valid & prod_ready.
  - prod_ready = ~out_valid | out_ready (combinational; no bubble under continuous flow).
  - Output transfer occurs when out_valid & out_ready.
- FSM, two states:
  - ACCUM: first flag cleared after any accepted non-last beat. Next group after a last beat restarts with first=1.
  - HOLD: out_valid=1. Leaves HOLD on an output transfer, unless a new last beat is accepted in the same cycle, in which case it stays in HOLD with the new result.
- Accumulate, per accepted beat:
  - sum = (first ? sext(cfg_bias) : acc) + sext(prod_data), computed at ACC_W, wrapping modulo 2^ACC_W.
  - first beat also latches cfg_shift.
  - if not last: acc <= sum.
  - if last: acc <= 0, first <= 1, result register loaded, out_valid <= 1, grp_cnt increments.
- Latency: result visible on out_data one cycle after the last beat is accepted.
- Group length: no overflow guaranteed up to 2^(ACC_W-PROD_W-1) beats; beyond that, wraparound is defined, not flagged.
- Requantize (combinational on sum, shift s = the latched value; on a single-beat group, the cfg_shift of that beat):
  - s=0: r = sum.
  - s>0: r = (sum + 2^(s-1)) >>> s, with the rounding add done at ACC_W+1 bits.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. If clipped, set sat_sticky.
- Single-beat group (first & last together): result = requant(bias + prod).
- Stalled output: out_data and out_valid hold steady while out_valid & ~out_ready; no beats are accepted.
- Reset mid-group discards the partial accumulation; any pending output is dropped.

Optional Feature:
- Macro: SKYNET_MAC_RELU_EN.
- Defined: negative rounded results are forced to 0 before saturation. A forced 0 does not set sat_sticky.
- Undefined: signed output across the full range.

Decomposition:
- Shared package skynet_mac_pkg:
  - constants PROD_W, ACC_W, OUT_W defaults;
  - typedefs for signed acc_t and out_t;
  - FSM state enum (ACCUM, HOLD).
- One natural sub-module: skynet_requant (round, shift, saturate, optional ReLU). Purely combinational; it provides the saturation indication that sets sat_sticky.

Test Plan:
- Products 100, 200, -50 (last on the third beat), bias=10, shift=2 -> sum 260, out_data=65 one cycle after the last beat; grp_cnt=1.
- Single beat: prod=5, bias=0, shift=1, last=1 -> (5+1)>>>1 = 3; then prod=-5 -> (-5+1)>>>1 = -2.
- Overflow: bias=0, prod=+500000, shift=0, last -> out_data=1023, sat_sticky=1. Separately, prod=-500000 -> -1024.
- Backpressure: out_ready=0 with a result pending -> prod_ready=0, out_data stable for 5 cycles. Release while a new last beat is offered -> back-to-back results with no bubble.
- Reset asserted after 2 of 4 beats -> outputs cleared. Next group prod=7, bias=0, shift=0, last -> out_data=7 with no leftover partial sum.
- With SKYNET_MAC_RELU_EN defined: sum=-40, shift=0 -> out_data=0, sat_sticky stays 0. Without the macro: out_data=-40.

Source files
------------

// File: rtl/skynet_mac_pkg.sv
// Shared constants, types and FSM states for the SkyNet MAC accumulator slice.
// Used by skynet_mac_accum and skynet_requant.
package skynet_mac_pkg;

    localparam int PROD_W = 20;
    localparam int BIAS_W = 20;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 11;
    localparam int CNT_W  = 16;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] out_t;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

endpackage

// File: rtl/skynet_requant.sv
// Combinational requantizer: round-half-up right shift, then saturate to OUT_W bits.
// Optional ReLU clamp of negative results when SKYNET_MAC_RELU_EN is defined.
module skynet_requant
    import skynet_mac_pkg::*;
#(
    parameter int ACC_W = skynet_mac_pkg::ACC_W,
    parameter int OUT_W = skynet_mac_pkg::OUT_W
) (
    input  logic signed [ACC_W-1:0] sum,
    input  logic        [4:0]       shift,
    output logic signed [OUT_W-1:0] res,
    output logic                    sat
);

    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(2**(OUT_W-1)));

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] r;

    // One extra bit keeps the rounding add from wrapping near the top of the range.
    always_comb begin
        ext  = {sum[ACC_W-1], sum};
        half = '0;
        r    = ext;
        if (shift != 5'd0) begin
            half = (ACC_W+1)'(1) << (shift - 5'd1);
            r    = (ext + half) >>> shift;
        end
`ifdef SKYNET_MAC_RELU_EN
        if (r < 0) begin
            r = '0;
        end
`endif
        sat = 1'b0;
        res = r[OUT_W-1:0];
        if (r > MAXV) begin
            res = MAXV[OUT_W-1:0];
            sat = 1'b1;
        end else if (r < MINV) begin
            res = MINV[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/skynet_mac_accum.sv
// Group accumulator for the SkyNet conv datapath: bias + sum of products, requantized,
// saturated and held in a single output register. Optional ReLU via SKYNET_MAC_RELU_EN.
module skynet_mac_accum
    import skynet_mac_pkg::*;
#(
    parameter int PROD_W = skynet_mac_pkg::PROD_W,
    parameter int BIAS_W = skynet_mac_pkg::BIAS_W,
    parameter int ACC_W  = skynet_mac_pkg::ACC_W,
    parameter int OUT_W  = skynet_mac_pkg::OUT_W,
    parameter int CNT_W  = skynet_mac_pkg::CNT_W
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic                     prod_last,
    input  logic signed [BIAS_W-1:0] cfg_bias,
    input  logic        [4:0]        cfg_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic        [CNT_W-1:0]  grp_cnt,
    output logic                     sat_sticky
);

    state_t state;
    state_t state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic                    first;
    logic        [4:0]       shift_q;
    logic        [4:0]       shift_use;
    logic signed [OUT_W-1:0] q_res;
    logic                    q_sat;
    logic                    accept;
    logic                    xfer;

    assign out_valid  = (state == HOLD);
    assign prod_ready = ~out_valid | out_ready;
    assign accept     = prod_valid & prod_ready;
    assign xfer       = out_valid & out_ready;

    // The first beat of a group uses the live bias/shift rather than the stored ones.
    assign shift_use = first ? cfg_shift : shift_q;
    assign base      = first ? ACC_W'(cfg_bias) : acc;
    assign sum       = base + ACC_W'(prod_data);

    skynet_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .sum   (sum),
        .shift (shift_use),
        .res   (q_res),
        .sat   (q_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // A new last beat accepted while draining the old result keeps HOLD without a bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (accept && prod_last) state_nxt = HOLD;
            HOLD: begin
                if (accept && prod_last) begin
                    state_nxt = HOLD;
                end else if (xfer) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc        <= '0;
            first      <= 1'b1;
            shift_q    <= '0;
            out_data   <= '0;
            grp_cnt    <= '0;
            sat_sticky <= 1'b0;
        end else if (accept) begin
            if (first) begin
                shift_q <= cfg_shift;
            end
            if (prod_last) begin
                acc      <= '0;
                first    <= 1'b1;
                out_data <= q_res;
                grp_cnt  <= grp_cnt + CNT_W'(1);
                if (q_sat) begin
                    sat_sticky <= 1'b1;
                end
            end else begin
                acc   <= sum;
                first <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_skynet_mac_accum.sv
// Self-checking bench for skynet_mac_accum: directed table, corner sequences, then
// randomized groups checked against an arithmetic reference model.
module tb_skynet_mac_accum;

`ifdef SKYNET_MAC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic               ap_clk;
    logic               ap_rst_n;
    logic               prod_valid;
    logic               prod_ready;
    logic signed [19:0] prod_data;
    logic               prod_last;
    logic signed [19:0] cfg_bias;
    logic        [4:0]  cfg_shift;
    logic               out_valid;
    logic               out_ready;
    logic signed [10:0] out_data;
    logic        [15:0] grp_cnt;
    logic               sat_sticky;

    int checks = 0;
    int errors = 0;
    bit monEn  = 1'b0;
    bit rndEn  = 1'b0;
    longint expQ[$];

    skynet_mac_accum dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .prod_last  (prod_last),
        .cfg_bias   (cfg_bias),
        .cfg_shift  (cfg_shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .grp_cnt    (grp_cnt),
        .sat_sticky (sat_sticky)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int prod;
        bit last;
        int bias;
        int shift;
        int expOut;
    } vec_t;

    function automatic int expNeg(input int v);
        return RELU ? 0 : v;
    endfunction

    // Reference requantizer: wrap to 32 bits, floor((sum + half) / 2^s), clamp.
    function automatic longint requantModel(input longint sum, input int s, output bit sat);
        longint w;
        longint r;
        w = longint'(int'(sum));
        if (s == 0) r = w;
        else        r = (w + (longint'(1) << (s - 1))) >>> s;
        if (RELU && r < 0) r = 0;
        sat = 1'b0;
        if (r > 1023) begin
            r = 1023;
            sat = 1'b1;
        end else if (r < -1024) begin
            r = -1024;
            sat = 1'b1;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offers one beat starting at a falling edge and returns 1ns after it is accepted.
    task automatic applyStimulus(input int prod, input bit last, input int bias,
                                 input int shift, input bit rdy);
        int w;
        @(negedge ap_clk);
        prod_valid = 1'b1;
        prod_data  = 20'(prod);
        prod_last  = last;
        cfg_bias   = 20'(bias);
        cfg_shift  = 5'(shift);
        out_ready  = rdy;
        #1;
        w = 0;
        while (!prod_ready && w < 100) begin
            @(negedge ap_clk);
            if (rndEn) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_accept_timeout: got prod_ready=0, expected 1");
            prod_valid = 1'b0;
        end else begin
            @(posedge ap_clk);
            #1;
            prod_valid = 1'b0;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge ap_clk);
            prod_valid = 1'b0;
            out_ready  = 1'b1;
        end
    endtask

    task automatic doReset();
        @(negedge ap_clk);
        ap_rst_n   = 1'b0;
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_grp_cnt", grp_cnt, 0);
        checkOutput("rst_sat_sticky", sat_sticky, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    // Compares each transferred result with the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge ap_clk);
            #1;
            if (monEn && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rand_unexpected: got result %0d, expected none", out_data);
                end else begin
                    checkOutput("rand_out", longint'(out_data), expQ.pop_front());
                end
            end
        end
    end

    initial begin
        vec_t   vecs[7];
        int     modelCnt;
        bit     modelSticky;
        bit     satBit;
        longint total;
        longint res;
        int     n;
        int     bias;
        int     shift;
        int     prods[6];
        int     w;

        ap_rst_n   = 1'b1;
        prod_valid = 1'b0;
        prod_data  = '0;
        prod_last  = 1'b0;
        cfg_bias   = '0;
        cfg_shift  = '0;
        out_ready  = 1'b1;
        #2;
        ap_rst_n = 1'b0;
        #1;
        checkOutput("init_out_valid", out_valid, 0);
        checkOutput("init_out_data", out_data, 0);
        checkOutput("init_grp_cnt", grp_cnt, 0);
        checkOutput("init_sat_sticky", sat_sticky, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Non-first beats carry junk bias/shift that must be ignored.
        vecs[0] = '{100, 1'b0, 10, 2, 0};
        vecs[1] = '{200, 1'b0, 999, 7, 0};
        vecs[2] = '{-50, 1'b1, -3, 9, 65};
        vecs[3] = '{5, 1'b1, 0, 1, 3};
        vecs[4] = '{-5, 1'b1, 0, 1, expNeg(-2)};
        vecs[5] = '{500000, 1'b1, 0, 0, 1023};
        vecs[6] = '{-500000, 1'b1, 0, 0, expNeg(-1024)};

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].prod, vecs[i].last, vecs[i].bias, vecs[i].shift, 1'b1);
            if (vecs[i].last) begin
                checkOutput($sformatf("vec%0d_valid", i), out_valid, 1);
                checkOutput($sformatf("vec%0d_data", i), longint'(out_data), vecs[i].expOut);
            end
            if (i == 2) checkOutput("vec2_grp_cnt", grp_cnt, 1);
        end
        checkOutput("table_grp_cnt", grp_cnt, 5);
        checkOutput("table_sat_sticky", sat_sticky, 1);

        idleCycles(2);
        applyStimulus(7, 1'b1, 0, 0, 1'b0);
        checkOutput("bp_first_data", longint'(out_data), 7);
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            #1;
            checkOutput($sformatf("bp_stall%0d_ready", c), prod_ready, 0);
            checkOutput($sformatf("bp_stall%0d_valid", c), out_valid, 1);
            checkOutput($sformatf("bp_stall%0d_data", c), longint'(out_data), 7);
        end
        applyStimulus(9, 1'b1, 0, 0, 1'b1);
        checkOutput("bp_b2b_valid", out_valid, 1);
        checkOutput("bp_b2b_data", longint'(out_data), 9);
        checkOutput("bp_b2b_grp_cnt", grp_cnt, 7);

        idleCycles(2);
        applyStimulus(1000, 1'b0, 0, 0, 1'b1);
        applyStimulus(2000, 1'b0, 0, 0, 1'b1);
        doReset();
        applyStimulus(7, 1'b1, 0, 0, 1'b1);
        checkOutput("post_rst_data", longint'(out_data), 7);
        checkOutput("post_rst_grp_cnt", grp_cnt, 1);

        idleCycles(1);
        applyStimulus(-40, 1'b1, 0, 0, 1'b1);
        checkOutput("relu_data", longint'(out_data), expNeg(-40));
        checkOutput("relu_sat_sticky", sat_sticky, 0);
        idleCycles(2);

        modelCnt    = 2;
        modelSticky = 1'b0;
        monEn       = 1'b1;
        rndEn       = 1'b1;
        for (int g = 0; g < 200; g++) begin
            n     = $urandom_range(1, 6);
            bias  = int'($urandom_range(0, 1048575)) - 524288;
            shift = $urandom_range(0, 31);
            total = bias;
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 1) == 0) prods[b] = int'($urandom_range(0, 1048575)) - 524288;
                else                           prods[b] = int'($urandom_range(0, 2000)) - 1000;
                total += prods[b];
            end
            res = requantModel(total, shift, satBit);
            expQ.push_back(res);
            modelSticky |= satBit;
            modelCnt++;
            for (int b = 0; b < n; b++) begin
                applyStimulus(prods[b], b == n - 1, b == 0 ? bias : int'($urandom_range(0, 500)),
                              b == 0 ? shift : int'($urandom_range(0, 31)),
                              $urandom_range(0, 3) != 0);
            end
        end
        @(negedge ap_clk);
        out_ready = 1'b1;
        w = 0;
        while (expQ.size() != 0 && w < 50) begin
            @(negedge ap_clk);
            w++;
        end
        checkOutput("rand_drain_left", expQ.size(), 0);
        monEn = 1'b0;
        checkOutput("rand_grp_cnt", grp_cnt, modelCnt & 16'hFFFF);
        checkOutput("rand_sat_sticky", sat_sticky, modelSticky);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
